lane_scheduler: RTL
===================

// Module: lane_scheduler
// PURPOSE
//   Central sequencer for the car lanes. Runs the game-phase FSM (idle/run/pause/over), tracks level and lives,
//   and issues one-cycle per-lane move strobes whose period shrinks with level. Drives the car controllers'
//   i_Game_Active and step timing so all lanes share one timebase; sits between top-level game logic and car instances.
// PARAMETERS
//   NUM_LANES       4         number of car lanes (1..8)
//   c_BASE_PERIOD   1650000   step period of lane 0 at level 0, in clocks
//   c_SPEED_STEP    150000    period reduction per level
//   c_MIN_PERIOD    300000    floor on level-adjusted period
//   c_LANE_SKEW     100000    extra period per lane index (lane k: +k*c_LANE_SKEW)
//   c_MAX_LEVEL     7         level saturates here (<=7)
//   c_LIVES         3         lives at game start (1..3)
//   c_PAUSE_CYCLES  25000000  freeze length after hit or level-up, in clocks
// PORTS
//   i_Clk           in   1          system clock
//   i_Rst           in   1          synchronous reset, active-high
//   i_Start         in   1          start/restart pulse (one cycle)
//   i_Hit           in   1          frog/car collision pulse
//   i_Level_Done    in   1          frog reached goal pulse
//   o_Cars_Active   out  1          to car controllers' i_Game_Active; 0 = hold at initial position
//   o_Lane_Step     out  NUM_LANES  one-cycle move strobe per lane
//   o_Lane_Dir      out  NUM_LANES  lane direction, bit k = k[0] (even right, odd left), constant
//   o_Level         out  3          current level, 0-based
//   o_Lives         out  2          remaining lives
//   o_State         out  2          00 IDLE, 01 RUN, 10 PAUSE, 11 OVER
// BEHAVIOUR
//   Reset (i_Rst=1 at edge): state IDLE, level 0, lives c_LIVES, pause counter 0, lane counters 0,
//     o_Lane_Step 0, o_Cars_Active 0. i_Rst overrides all other inputs, including mid-RUN/PAUSE.
//   Period: P = max(c_BASE_PERIOD - level*c_SPEED_STEP, c_MIN_PERIOD), computed without underflow
//     (subtraction saturates to c_MIN_PERIOD); lane k period Pk = P + k*c_LANE_SKEW. 32-bit arithmetic.
//   Lane counter k (RUN only): increments each clock; when count == Pk-1, o_Lane_Step[k]=1 for the next
//     cycle (registered, latency 1) and count <= 0. Outside RUN, counters hold 0 and all steps are 0.
//   Level change takes effect for the next period; counters cleared on every entry to RUN.
//   FSM (registered outputs, change one cycle after the triggering edge):
//     IDLE : i_Start -> RUN; level <= 0, lives <= c_LIVES. Other inputs ignored.
//     RUN  : i_Hit -> if lives==1: lives <= 0, OVER; else lives <= lives-1, PAUSE.
//            else i_Level_Done -> level <= min(level+1, c_MAX_LEVEL), PAUSE.
//            i_Hit and i_Level_Done same cycle: hit wins, level unchanged. i_Start ignored.
//     PAUSE: counts 0..c_PAUSE_CYCLES-1 then RUN; i_Hit/i_Level_Done/i_Start ignored.
//     OVER : i_Start -> RUN with level 0, lives c_LIVES (full reinit).
//   o_Cars_Active = 1 in RUN and PAUSE, 0 in IDLE and OVER (cars respawn at initial position).
//   Level at c_MAX_LEVEL plus i_Level_Done: level stays, still enters PAUSE.
// TESTING (sim params: BASE=20, STEP=4, MIN=6, SKEW=2, PAUSE=5, LIVES=3, NUM_LANES=4)
//   Reset then i_Start -> o_State=01 next cycle; lane0 strobes every 20 clks, lane3 every 26; o_Lane_Dir=4'b1010.
//   i_Level_Done x4 (wait out each pause) -> level 4, P=max(20-16,6)=6, lane0 period 6; level clamps at 7.
//   i_Hit in RUN -> lives 3->2, state PAUSE, no strobes for 5 clks, back to RUN with counters restarted.
//   i_Hit and i_Level_Done same cycle -> lives decrement, level unchanged.
//   Third hit -> lives 0, state OVER, o_Cars_Active 0; i_Start -> RUN, level 0, lives 3.
//   i_Rst asserted mid-PAUSE and mid-strobe -> next cycle IDLE, all strobes 0, level 0, lives 3.

Source files
------------

// File: rtl/lane_scheduler.sv
// Game-phase sequencer for the car lanes: IDLE/RUN/PAUSE/OVER FSM, level and lives
// bookkeeping, and level-dependent per-lane one-cycle move strobes on a shared timebase.
module lane_scheduler #(
  parameter int unsigned NUM_LANES      = 4,
  parameter int unsigned c_BASE_PERIOD  = 1650000,
  parameter int unsigned c_SPEED_STEP   = 150000,
  parameter int unsigned c_MIN_PERIOD   = 300000,
  parameter int unsigned c_LANE_SKEW    = 100000,
  parameter int unsigned c_MAX_LEVEL    = 7,
  parameter int unsigned c_LIVES        = 3,
  parameter int unsigned c_PAUSE_CYCLES = 25000000
) (
  input  logic                 i_Clk,
  input  logic                 i_Rst,
  input  logic                 i_Start,
  input  logic                 i_Hit,
  input  logic                 i_Level_Done,
  output logic                 o_Cars_Active,
  output logic [NUM_LANES-1:0] o_Lane_Step,
  output logic [NUM_LANES-1:0] o_Lane_Dir,
  output logic [2:0]           o_Level,
  output logic [1:0]           o_Lives,
  output logic [1:0]           o_State
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_PAUSE = 2'b10,
    ST_OVER  = 2'b11
  } state_t;

  localparam logic [31:0] LP_BASE  = 32'(c_BASE_PERIOD);
  localparam logic [31:0] LP_STEP  = 32'(c_SPEED_STEP);
  localparam logic [31:0] LP_MIN   = 32'(c_MIN_PERIOD);
  localparam logic [31:0] LP_SKEW  = 32'(c_LANE_SKEW);
  localparam logic [31:0] LP_PAUSE = 32'(c_PAUSE_CYCLES);
  localparam logic [2:0]  LP_MAXL  = 3'(c_MAX_LEVEL);
  localparam logic [1:0]  LP_LIVES = 2'(c_LIVES);

  state_t      r_State;
  logic [2:0]  r_Level;
  logic [1:0]  r_Lives;
  logic [31:0] r_Pause_Cnt;
  logic        r_Cars_Active;
  logic [31:0] r_Lane_Cnt [NUM_LANES];
  logic [NUM_LANES-1:0] r_Lane_Step;

  logic [31:0] w_Base_Period;
  logic [31:0] w_Lane_Period [NUM_LANES];
  logic        w_Leave_Run;
  logic        w_Count_En;

  // Level-adjusted period; the subtraction saturates at the floor instead of wrapping.
  function automatic logic [31:0] f_level_period(input logic [2:0] lvl);
    logic [31:0] dec;
    dec = 32'(lvl) * LP_STEP;
    if (dec >= LP_BASE)
      return LP_MIN;
    else if ((LP_BASE - dec) < LP_MIN)
      return LP_MIN;
    else
      return LP_BASE - dec;
  endfunction

  assign w_Base_Period = f_level_period(r_Level);

  always_comb begin
    for (int k = 0; k < NUM_LANES; k++) begin
      w_Lane_Period[k] = w_Base_Period + 32'(k) * LP_SKEW;
    end
  end

  // Counting stops on the very edge that leaves RUN so no strobe lands in PAUSE/OVER.
  assign w_Leave_Run = (r_State == ST_RUN) && (i_Hit || i_Level_Done);
  assign w_Count_En  = (r_State == ST_RUN) && !w_Leave_Run;

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      r_State       <= ST_IDLE;
      r_Level       <= 3'd0;
      r_Lives       <= LP_LIVES;
      r_Pause_Cnt   <= 32'd0;
      r_Cars_Active <= 1'b0;
    end else begin
      case (r_State)
        ST_IDLE, ST_OVER: begin
          if (i_Start) begin
            r_State       <= ST_RUN;
            r_Level       <= 3'd0;
            r_Lives       <= LP_LIVES;
            r_Cars_Active <= 1'b1;
          end
        end
        ST_RUN: begin
          if (i_Hit) begin
            r_Pause_Cnt <= 32'd0;
            if (r_Lives <= 2'd1) begin
              r_Lives       <= 2'd0;
              r_State       <= ST_OVER;
              r_Cars_Active <= 1'b0;
            end else begin
              r_Lives <= r_Lives - 2'd1;
              r_State <= ST_PAUSE;
            end
          end else if (i_Level_Done) begin
            r_Pause_Cnt <= 32'd0;
            r_State     <= ST_PAUSE;
            if (r_Level < LP_MAXL)
              r_Level <= r_Level + 3'd1;
          end
        end
        ST_PAUSE: begin
          if (r_Pause_Cnt == LP_PAUSE - 32'd1) begin
            r_Pause_Cnt <= 32'd0;
            r_State     <= ST_RUN;
          end else begin
            r_Pause_Cnt <= r_Pause_Cnt + 32'd1;
          end
        end
        default: r_State <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_Clk) begin
    for (int k = 0; k < NUM_LANES; k++) begin
      if (i_Rst || !w_Count_En) begin
        r_Lane_Cnt[k]  <= 32'd0;
        r_Lane_Step[k] <= 1'b0;
      end else if (r_Lane_Cnt[k] == w_Lane_Period[k] - 32'd1) begin
        r_Lane_Cnt[k]  <= 32'd0;
        r_Lane_Step[k] <= 1'b1;
      end else begin
        r_Lane_Cnt[k]  <= r_Lane_Cnt[k] + 32'd1;
        r_Lane_Step[k] <= 1'b0;
      end
    end
  end

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_dir
    assign o_Lane_Dir[g] = ((g % 2) == 1);
  end

  assign o_Cars_Active = r_Cars_Active;
  assign o_Lane_Step   = r_Lane_Step;
  assign o_Level       = r_Level;
  assign o_Lives       = r_Lives;
  assign o_State       = r_State;

endmodule
